// File: rtl/compuertas_logicas_if.sv
// compuertas_logicas_if: operand/enable and gate-result bundle for the logic gate bank
interface compuertas_logicas_if #(parameter int WIDTH = 1);
  logic             en;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] S1;
  logic [WIDTH-1:0] S2;
  logic [WIDTH-1:0] S3;
  logic [WIDTH-1:0] S4;
  logic [WIDTH-1:0] S5;
  logic [WIDTH-1:0] S6;
  logic [WIDTH-1:0] S7;
  logic [WIDTH-1:0] S8;
  logic             valid;
  modport master (output en, A, B, input S1, S2, S3, S4, S5, S6, S7, S8, valid);
  modport slave  (input en, A, B, output S1, S2, S3, S4, S5, S6, S7, S8, valid);
endinterface

// File: rtl/compuertas_logicas.sv
// compuertas_logicas: registered bank of eight bitwise two-input gates
module compuertas_logicas #(
  parameter int WIDTH = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  compuertas_logicas_if.slave bus
);
  logic [7:0][WIDTH-1:0] s_q, s_d;
  logic                  valid_q, valid_d;
  // Element 0 is S1 (AND) up to element 7 (XNOR)
  always_comb begin
    s_d     = bus.en ? {~(bus.A ^ bus.B), bus.A ^ bus.B, ~(bus.A | bus.B), ~(bus.A & bus.B),
                        ~bus.B, ~bus.A, bus.A | bus.B, bus.A & bus.B} : s_q;
    valid_d = bus.en ? 1'b1 : valid_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      valid_q <= valid_d;
    end
  end
  assign bus.S1    = s_q[0];
  assign bus.S2    = s_q[1];
  assign bus.S3    = s_q[2];
  assign bus.S4    = s_q[3];
  assign bus.S5    = s_q[4];
  assign bus.S6    = s_q[5];
  assign bus.S7    = s_q[6];
  assign bus.S8    = s_q[7];
  assign bus.valid = valid_q;
endmodule

// File: tb/tb_compuertas_logicas.sv
// tb_compuertas_logicas: directed checks of the gate bank at WIDTH 1 and WIDTH 4
module tb_compuertas_logicas;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  compuertas_logicas_if #(.WIDTH(1)) b1 ();
  compuertas_logicas_if #(.WIDTH(4)) b4 ();
  compuertas_logicas #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  compuertas_logicas #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  // S1..S8 packed in reading order so expected values match the truth table text
  function automatic logic [7:0] outs1();
    return {b1.S1, b1.S2, b1.S3, b1.S4, b1.S5, b1.S6, b1.S7, b1.S8};
  endfunction
  function automatic logic [31:0] outs4();
    return {b4.S1, b4.S2, b4.S3, b4.S4, b4.S5, b4.S6, b4.S7, b4.S8};
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    b1.en = 1'b0; b1.A = 1'b0; b1.B = 1'b0;
    b4.en = 1'b0; b4.A = 4'h0; b4.B = 4'h0;
    #2;
    checks++;
    if (outs1() !== 8'h00 || b1.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_w1: outs=%b valid=%b, want 00000000 valid=0", outs1(), b1.valid);
    end
    checks++;
    if (outs4() !== 32'h0 || b4.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_w4: outs=%h valid=%b, want 00000000 valid=0", outs4(), b4.valid);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    checks++;
    if (b1.valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: valid=%b, want 0", b1.valid);
    end
  endtask
  task automatic test_truth_table();
    logic [7:0] exp_tab [4] = '{8'b00111101, 8'b01101010, 8'b01011010, 8'b11000001};
    for (int i = 0; i < 4; i++) begin
      logic [1:0] v;
      v = 2'(i);
      b1.A = v[1]; b1.B = v[0]; b1.en = 1'b1;
      cyc();
      checks++;
      if (outs1() !== exp_tab[i] || b1.valid !== 1'b1) begin
        errors++;
        $display("FAIL truth_A%0bB%0b: outs=%b valid=%b, want %b valid=1", v[1], v[0], outs1(), b1.valid, exp_tab[i]);
      end
    end
  endtask
  task automatic test_no_comb_path();
    b1.en = 1'b1; b1.A = 1'b0; b1.B = 1'b1;
    #2;
    checks++;
    if (outs1() !== 8'b11000001) begin
      errors++;
      $display("FAIL no_comb_path: outs=%b before edge, want 11000001", outs1());
    end
    cyc();
    checks++;
    if (outs1() !== 8'b01101010) begin
      errors++;
      $display("FAIL latency_one: outs=%b, want 01101010", outs1());
    end
  endtask
  task automatic test_hold();
    b1.A = 1'b1; b1.B = 1'b0; b1.en = 1'b1;
    cyc();
    b1.en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b1.A = ~b1.A;
      b1.B = (i % 2 == 0) ? 1'b1 : 1'b0;
      cyc();
      checks++;
      if (outs1() !== 8'b01011010 || b1.valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_%0d: outs=%b valid=%b, want 01011010 valid=1", i, outs1(), b1.valid);
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [1:0] seq [4] = '{2'b11, 2'b00, 2'b10, 2'b01};
    logic [7:0] exp_seq [4] = '{8'b11000001, 8'b00111101, 8'b01011010, 8'b01101010};
    b1.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b1.A = seq[i][1]; b1.B = seq[i][0];
      cyc();
      checks++;
      if (outs1() !== exp_seq[i]) begin
        errors++;
        $display("FAIL back_to_back_%0d: outs=%b, want %b", i, outs1(), exp_seq[i]);
      end
    end
    b1.en = 1'b0;
  endtask
  task automatic test_width4();
    b4.A = 4'b1100; b4.B = 4'b1010; b4.en = 1'b1;
    cyc();
    checks++;
    if (b4.S1 !== 4'b1000 || b4.S7 !== 4'b0110 || b4.S6 !== 4'b0001) begin
      errors++;
      $display("FAIL w4_and_xor_nor: S1=%b S7=%b S6=%b, want 1000 0110 0001", b4.S1, b4.S7, b4.S6);
    end
    checks++;
    if (outs4() !== {4'b1000, 4'b1110, 4'b0011, 4'b0101, 4'b0111, 4'b0001, 4'b0110, 4'b1001} || b4.valid !== 1'b1) begin
      errors++;
      $display("FAIL w4_all: outs=%b valid=%b, want 1000_1110_0011_0101_0111_0001_0110_1001 valid=1", outs4(), b4.valid);
    end
    b4.A = 4'b0110; b4.B = 4'b0011;
    cyc();
    checks++;
    if (outs4() !== {4'b0010, 4'b0111, 4'b1001, 4'b1100, 4'b1101, 4'b1000, 4'b0101, 4'b1010}) begin
      errors++;
      $display("FAIL w4_second: outs=%b, want 0010_0111_1001_1100_1101_1000_0101_1010", outs4());
    end
    b4.en = 1'b0;
  endtask
  task automatic test_reset_mid();
    b1.A = 1'b1; b1.B = 1'b1; b1.en = 1'b1;
    cyc();
    b1.en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs1() !== 8'h00 || b1.valid !== 1'b0 || outs4() !== 32'h0 || b4.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: w1=%b v1=%b w4=%h v4=%b, want all 0", outs1(), b1.valid, outs4(), b4.valid);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    checks++;
    if (b1.valid !== 1'b0 || outs1() !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_idle: outs=%b valid=%b, want 00000000 valid=0", outs1(), b1.valid);
    end
    b1.A = 1'b0; b1.B = 1'b0; b1.en = 1'b1;
    cyc();
    checks++;
    if (outs1() !== 8'b00111101 || b1.valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_capture: outs=%b valid=%b, want 00111101 valid=1", outs1(), b1.valid);
    end
  endtask
  initial begin
    test_reset();
    test_truth_table();
    test_no_comb_path();
    test_hold();
    test_back_to_back();
    test_width4();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
